// File: rtl/rx_sequencer.sv
// rx_sequencer: control unit for the serial receive path.
//   Takes the already-synchronized serial line, detects the start bit,
//   samples every bit in the middle of its period, assembles the frame
//   LSB-first and presents the byte through a ready/read handshake.
//   The macro RX_PARITY_EN adds an even-parity bit between the data bits
//   and the stop bit. Without it, parity_error is tied low.
// Ports:
//   clk           - system clock, all logic on posedge
//   n_rst         - synchronous active-low reset
//   serial_in     - synchronized serial line, idle high
//   data_read     - consumer acknowledges rx_data this cycle
//   rx_data       - last good frame, LSB = first bit received
//   data_ready    - rx_data valid and not yet read
//   framing_error - last frame had stop bit = 0
//   overrun_error - an unread frame was overwritten
//   parity_error  - last frame failed even parity (RX_PARITY_EN only)
//   busy          - FSM is in any state other than IDLE
// Handshake: data_ready is the valid flag and data_read is the
//   acknowledge. A data_read while data_ready=1 consumes the byte, and
//   data_ready drops on the following cycle. A data_read while
//   data_ready=0 is ignored. A new frame never waits for the consumer;
//   it overwrites the old byte and raises overrun_error instead.
module rx_sequencer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  // The counter reloads to 0 on the cycle after the edge, so the mid-start
  // sample falls at count HALF-1.
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_LOAD   = 3'd5;
`ifdef RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_in_q;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 data_ready_q, data_ready_d;
  logic                 framing_q, framing_d;
  logic                 overrun_q, overrun_d;
`ifdef RX_PARITY_EN
  logic                 parity_q, parity_d;
  logic                 par_bad_q, par_bad_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    data_ready_d = data_ready_q;
    framing_d    = framing_q;
    overrun_d    = overrun_q;
`ifdef RX_PARITY_EN
    parity_d     = parity_q;
    par_bad_d    = par_bad_q;
`endif

    // Consumer acknowledge; LOAD below may re-assert both flags.
    if (data_read && data_ready_q) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!serial_in && serial_in_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!serial_in) begin
            state_d   = ST_DATA;
            bit_d     = '0;
            framing_d = 1'b0;
`ifdef RX_PARITY_EN
            parity_d  = 1'b0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d                 = '0;
          shift_d               = shift_q >> 1;
          shift_d[DATA_BITS-1]  = serial_in;
          bit_d                 = bit_q + BW'(1);
          if (bit_q == BIT_LAST) begin
`ifdef RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = (^shift_q) ^ serial_in;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (serial_in) begin
            state_d = ST_LOAD;
          end else begin
            framing_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_LOAD: begin
        rx_data_d    = shift_q;
        data_ready_d = 1'b1;
        if (data_ready_q && !data_read) overrun_d = 1'b1;
`ifdef RX_PARITY_EN
        parity_d     = par_bad_q;
`endif
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      serial_in_q  <= 1'b1;
      rx_data_q    <= '0;
      data_ready_q <= 1'b0;
      framing_q    <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef RX_PARITY_EN
      parity_q     <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      serial_in_q  <= serial_in;
      rx_data_q    <= rx_data_d;
      data_ready_q <= data_ready_d;
      framing_q    <= framing_d;
      overrun_q    <= overrun_d;
`ifdef RX_PARITY_EN
      parity_q     <= parity_d;
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  assign rx_data       = rx_data_q;
  assign data_ready    = data_ready_q;
  assign framing_error = framing_q;
  assign overrun_error = overrun_q;
  assign busy          = (state_q != ST_IDLE);
`ifdef RX_PARITY_EN
  assign parity_error  = parity_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_rx_sequencer.sv
// Directed bench for rx_sequencer with CLKS_PER_BIT=10, DATA_BITS=8.
// Cycle convention: tick() returns 1 time unit after a posedge. Inputs set
// then are seen during the current cycle, and outputs read then show the
// registers updated at the edge just passed. "Cycle E" is the cycle in
// which the start bit is first driven low.
module tb_rx_sequencer;

  logic       clk;
  logic       n_rst;
  logic       serial_in;
  logic       data_read;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       framing_error;
  logic       overrun_error;
  logic       parity_error;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  rx_sequencer #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .data_read     (data_read),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .parity_error  (parity_error),
    .busy          (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a frame starting in the current cycle (E) and returns in cycle
  // S+1, where S is the stop-bit sample cycle. The line is left at the
  // stop-bit value.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic par_en, input logic par_bit);
    logic [10:0] seq;
    int          nbits;
    seq      = '0;
    seq[8:1] = data;
    if (par_en) begin
      seq[9]  = par_bit;
      seq[10] = stop_bit;
      nbits   = 11;
    end else begin
      seq[9]  = stop_bit;
      nbits   = 10;
    end
    for (int i = 0; i <= nbits * 10 - 5; i++) begin
      serial_in = seq[i / 10];
      tick();
    end
  endtask

  task automatic read_byte();
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      serial_in = i[0];
      tick();
    end
    serial_in = 1'b1;
    n_rst     = 1'b1;
    n_checks++;
    if ({rx_data, data_ready, framing_error, overrun_error, parity_error, busy} !== 13'h0)
      $display("FAIL reset: got rx=%h rdy=%b fe=%b oe=%b pe=%b busy=%b, want all 0",
               rx_data, data_ready, framing_error, overrun_error, parity_error, busy);
    else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b1;
    // cycle E+96: LOAD, byte not yet visible
    n_checks++;
    if (busy !== 1'b1 || data_ready !== 1'b0)
      $display("FAIL good_load_cycle: busy=%b rdy=%b, want busy=1 rdy=0", busy, data_ready);
    else n_pass++;
    tick();
    // cycle E+97
    n_checks++;
    if (rx_data !== 8'hA5 || data_ready !== 1'b1 || busy !== 1'b0 || framing_error !== 1'b0)
      $display("FAIL good_frame: rx=%h rdy=%b busy=%b fe=%b, want A5 1 0 0",
               rx_data, data_ready, busy, framing_error);
    else n_pass++;
    read_byte();
    n_checks++;
    if (data_ready !== 1'b0 || rx_data !== 8'hA5)
      $display("FAIL good_read: rdy=%b rx=%h, want 0 A5", data_ready, rx_data);
    else n_pass++;
    // extra data_read with nothing pending is ignored
    read_byte();
    n_checks++;
    if (data_ready !== 1'b0 || overrun_error !== 1'b0)
      $display("FAIL idle_read: rdy=%b oe=%b, want 0 0", data_ready, overrun_error);
    else n_pass++;
  endtask

  task automatic test_glitch();
    serial_in = 1'b0;
    tick(); tick(); tick();
    serial_in = 1'b1;
    // now in cycle E+3: START
    n_checks++;
    if (busy !== 1'b1)
      $display("FAIL glitch_start: busy=%b, want 1", busy);
    else n_pass++;
    tick(); tick(); tick();
    // cycle E+6: back in IDLE after the E+5 sample saw 1
    n_checks++;
    if (busy !== 1'b0 || data_ready !== 1'b0 || framing_error !== 1'b0 || overrun_error !== 1'b0)
      $display("FAIL glitch_abort: busy=%b rdy=%b fe=%b oe=%b, want all 0",
               busy, data_ready, framing_error, overrun_error);
    else n_pass++;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    // cycle E+96
    n_checks++;
    if (framing_error !== 1'b1 || data_ready !== 1'b0 || rx_data !== 8'hA5 || busy !== 1'b0)
      $display("FAIL framing: fe=%b rdy=%b rx=%h busy=%b, want 1 0 A5 0",
               framing_error, data_ready, rx_data, busy);
    else n_pass++;
    tick(); tick();
    serial_in = 1'b1;
    tick(); tick();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b1;
    tick();
    n_checks++;
    if (framing_error !== 1'b0 || rx_data !== 8'h5A || data_ready !== 1'b1)
      $display("FAIL framing_clear: fe=%b rx=%h rdy=%b, want 0 5A 1",
               framing_error, rx_data, data_ready);
    else n_pass++;
    read_byte();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b1;
    tick();
    // cycle E+97 = next start edge
    n_checks++;
    if (rx_data !== 8'h11 || data_ready !== 1'b1 || overrun_error !== 1'b0)
      $display("FAIL b2b_first: rx=%h rdy=%b oe=%b, want 11 1 0", rx_data, data_ready, overrun_error);
    else n_pass++;
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b1;
    tick();
    n_checks++;
    if (rx_data !== 8'h22 || data_ready !== 1'b1 || overrun_error !== 1'b1)
      $display("FAIL b2b_overrun: rx=%h rdy=%b oe=%b, want 22 1 1", rx_data, data_ready, overrun_error);
    else n_pass++;
    read_byte();
    n_checks++;
    if (data_ready !== 1'b0 || overrun_error !== 1'b0)
      $display("FAIL b2b_read: rdy=%b oe=%b, want 0 0", data_ready, overrun_error);
    else n_pass++;
    tick();
  endtask

  task automatic test_load_with_read();
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b1;
    tick();
    send_frame(8'h44, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b1;
    // read 0x33 in the very cycle the new frame loads
    read_byte();
    n_checks++;
    if (rx_data !== 8'h44 || data_ready !== 1'b1 || overrun_error !== 1'b0)
      $display("FAIL load_read: rx=%h rdy=%b oe=%b, want 44 1 0", rx_data, data_ready, overrun_error);
    else n_pass++;
    read_byte();
    n_checks++;
    if (data_ready !== 1'b0)
      $display("FAIL load_read_clear: rdy=%b, want 0", data_ready);
    else n_pass++;
    tick();
  endtask

  task automatic test_parity();
`ifdef RX_PARITY_EN
    // 0x07 has three ones: parity bit 0 breaks even parity
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    serial_in = 1'b1;
    tick();
    n_checks++;
    if (parity_error !== 1'b1 || rx_data !== 8'h07 || data_ready !== 1'b1)
      $display("FAIL parity_bad: pe=%b rx=%h rdy=%b, want 1 07 1", parity_error, rx_data, data_ready);
    else n_pass++;
    read_byte();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    serial_in = 1'b1;
    tick();
    n_checks++;
    if (parity_error !== 1'b0 || rx_data !== 8'h07 || data_ready !== 1'b1)
      $display("FAIL parity_good: pe=%b rx=%h rdy=%b, want 0 07 1", parity_error, rx_data, data_ready);
    else n_pass++;
    read_byte();
`else
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b1;
    tick();
    n_checks++;
    if (parity_error !== 1'b0 || rx_data !== 8'h07 || data_ready !== 1'b1)
      $display("FAIL parity_off: pe=%b rx=%h rdy=%b, want 0 07 1", parity_error, rx_data, data_ready);
    else n_pass++;
    read_byte();
`endif
    tick();
  endtask

  task automatic test_reset_mid_frame();
    serial_in = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    n_checks++;
    if (busy !== 1'b1)
      $display("FAIL mid_frame_busy: busy=%b, want 1", busy);
    else n_pass++;
    n_rst = 1'b0;
    tick();
    n_rst     = 1'b1;
    serial_in = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || framing_error !== 1'b0 || data_ready !== 1'b0 || rx_data !== 8'h00)
      $display("FAIL mid_frame_reset: busy=%b fe=%b rdy=%b rx=%h, want 0 0 0 00",
               busy, framing_error, data_ready, rx_data);
    else n_pass++;
    for (int i = 0; i < 100; i++) tick();
    n_checks++;
    if (busy !== 1'b0 || framing_error !== 1'b0 || data_ready !== 1'b0)
      $display("FAIL mid_frame_quiet: busy=%b fe=%b rdy=%b, want 0 0 0", busy, framing_error, data_ready);
    else n_pass++;
  endtask

  initial begin
    n_rst     = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    test_reset();
    test_good_frame();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_load_with_read();
    test_parity();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
